// File: rtl/safe_lock_core.sv
// safe_lock_core: combination-lock engine. Conditions raw button pins,
// collects a CODE_LEN-digit BCD entry, checks it against the stored code,
// and handles open/reprogram, wrong-code counting and timed lockout.
module safe_lock_core #(
  parameter int                      CODE_LEN     = 4,
  parameter int                      MAX_FAIL     = 3,
  parameter int                      LOCKOUT_CYC  = 1024,
  parameter logic [4*CODE_LEN-1:0]   DEFAULT_CODE = 16'h1234
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_digit,
  input  logic       key_stb,
  input  logic       enter,
  input  logic       clear,
  input  logic       relock,
  output logic       unlocked,
  output logic       lockout,
  output logic       err,
  output logic       prog_ack,
  output logic [2:0] digit_cnt,
  output logic [1:0] fail_cnt
);

  localparam int W  = 4 * CODE_LEN;
  localparam int TW = $clog2(LOCKOUT_CYC);

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_OPEN    = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_t;

  // Button bit order: 0 clear, 1 enter, 2 key_stb, 3 relock
  logic [3:0] btn_s1, btn_s2, btn_s3, btn_ev;
  logic [3:0] dig_s1, dig_s2, dig_s3;

  state_t          state, state_n;
  logic [W-1:0]    code, code_n;
  logic [W-1:0]    entry_buf, entry_buf_n;
  logic [2:0]      cnt, cnt_n;
  logic [1:0]      fail, fail_n;
  logic            err_q, err_n;
  logic            ack_q, ack_n;
  logic [TW-1:0]   timer, timer_n;
  logic            unlocked_q, lockout_q;

  logic            ev_clr, ev_ent, ev_key, ev_rel;
  logic            full;
  logic [1:0]      fail_inc;

  assign ev_clr   = btn_ev[0];
  assign ev_ent   = btn_ev[1];
  assign ev_key   = btn_ev[2];
  assign ev_rel   = btn_ev[3];
  assign full     = (cnt == 3'(CODE_LEN));
  assign fail_inc = fail + 2'd1;

  // Two-FF synchronisers plus a registered rising-edge pulse; the digit
  // bus gets one extra stage so it lines up with the registered key event.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      btn_s3 <= '0;
      btn_ev <= '0;
      dig_s1 <= '0;
      dig_s2 <= '0;
      dig_s3 <= '0;
    end else begin
      btn_s1 <= {relock, key_stb, enter, clear};
      btn_s2 <= btn_s1;
      btn_s3 <= btn_s2;
      btn_ev <= btn_s2 & ~btn_s3;
      dig_s1 <= key_digit;
      dig_s2 <= dig_s1;
      dig_s3 <= dig_s2;
    end
  end

  // State, code, entry buffer, counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_ENTRY;
      code       <= DEFAULT_CODE;
      entry_buf  <= '0;
      cnt        <= '0;
      fail       <= '0;
      err_q      <= 1'b0;
      ack_q      <= 1'b0;
      timer      <= '0;
      unlocked_q <= 1'b0;
      lockout_q  <= 1'b0;
    end else begin
      state      <= state_n;
      code       <= code_n;
      entry_buf  <= entry_buf_n;
      cnt        <= cnt_n;
      fail       <= fail_n;
      err_q      <= err_n;
      ack_q      <= ack_n;
      timer      <= timer_n;
      unlocked_q <= (state_n == ST_OPEN);
      lockout_q  <= (state_n == ST_LOCKOUT);
    end
  end

  // Next-state logic; only the highest-priority event acts in a cycle.
  always_comb begin
    state_n     = state;
    code_n      = code;
    entry_buf_n = entry_buf;
    cnt_n       = cnt;
    fail_n      = fail;
    err_n       = err_q;
    ack_n       = 1'b0;
    timer_n     = timer;
    case (state)
      ST_LOCKOUT: begin
        if (timer == '0) begin
          state_n = ST_ENTRY;
          fail_n  = '0;
          err_n   = 1'b0;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      ST_ENTRY, ST_OPEN: begin
        if (ev_clr) begin
          entry_buf_n = '0;
          cnt_n       = '0;
          err_n       = 1'b0;
        end else if (ev_ent) begin
          entry_buf_n = '0;
          cnt_n       = '0;
          if (state == ST_OPEN) begin
            err_n = 1'b0;
            if (full) begin
              code_n = entry_buf;
              ack_n  = 1'b1;
            end
          end else if (full && (entry_buf == code)) begin
            state_n = ST_OPEN;
            fail_n  = '0;
            err_n   = 1'b0;
          end else begin
            err_n  = 1'b1;
            fail_n = (fail == 2'(MAX_FAIL)) ? fail : fail_inc;
            if (fail_inc == 2'(MAX_FAIL)) begin
              state_n = ST_LOCKOUT;
              timer_n = TW'(LOCKOUT_CYC - 1);
            end
          end
        end else if (ev_key) begin
          if (dig_s3 <= 4'd9) begin
            err_n = 1'b0;
            if (!full) begin
              entry_buf_n = W'({entry_buf, dig_s3});
              cnt_n       = cnt + 3'd1;
            end
          end
        end else if (ev_rel && (state == ST_OPEN)) begin
          state_n     = ST_ENTRY;
          entry_buf_n = '0;
          cnt_n       = '0;
          err_n       = 1'b0;
        end
      end
      default: state_n = ST_ENTRY;
    endcase
  end

  assign unlocked  = unlocked_q;
  assign lockout   = lockout_q;
  assign err       = err_q;
  assign prog_ack  = ack_q;
  assign digit_cnt = cnt;
  assign fail_cnt  = fail;

endmodule

// File: tb/tb_safe_lock_core.sv
// Bench for safe_lock_core: a pin-level behavioural model (digit queues,
// cycle counters, pin history) checked every cycle, plus directed scenarios
// with literal expectations and a randomized phase.
module tb_safe_lock_core;

  localparam int CL = 4;
  localparam int MF = 3;
  localparam int LC = 1024;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_digit = '0;
  logic       key_stb = 1'b0, enter = 1'b0, clear = 1'b0, relock = 1'b0;
  logic       unlocked, lockout, err, prog_ack;
  logic [2:0] digit_cnt;
  logic [1:0] fail_cnt;

  safe_lock_core #(
    .CODE_LEN(CL), .MAX_FAIL(MF), .LOCKOUT_CYC(LC), .DEFAULT_CODE(16'h1234)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_digit(key_digit), .key_stb(key_stb),
    .enter(enter), .clear(clear), .relock(relock), .unlocked(unlocked),
    .lockout(lockout), .err(err), .prog_ack(prog_ack),
    .digit_cnt(digit_cnt), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_state;        // 0 entry, 1 open, 2 locked out
  int m_entry[$];
  int m_code[$];
  int m_fail;
  int m_lock_seen;
  bit m_err, m_ack;
  bit hist[4][4];     // [button][age]; age 0 = pin value at previous edge
  int dhist[4];

  function automatic bit entry_matches();
    if (m_entry.size() != CL) return 1'b0;
    for (int i = 0; i < CL; i++)
      if (m_entry[i] != m_code[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    bit cur[4];
    bit ev[4];
    int dig;
    cur = '{clear, enter, key_stb, relock};
    for (int b = 0; b < 4; b++) ev[b] = hist[b][2] && !hist[b][3];
    dig = dhist[2];
    m_ack = 1'b0;
    if (!rst_n) begin
      m_state = 0; m_entry.delete(); m_code = '{1, 2, 3, 4};
      m_fail = 0; m_err = 1'b0; m_lock_seen = 0;
      for (int b = 0; b < 4; b++) for (int a = 0; a < 4; a++) hist[b][a] = 1'b0;
      for (int a = 0; a < 4; a++) dhist[a] = 0;
      return;
    end
    if (m_state == 2) begin
      m_lock_seen++;
      if (m_lock_seen == LC) begin
        m_state = 0; m_fail = 0; m_err = 1'b0;
      end
    end else if (ev[0]) begin
      m_entry.delete(); m_err = 1'b0;
    end else if (ev[1]) begin
      if (m_state == 1) begin
        if (m_entry.size() == CL) begin
          m_code = m_entry; m_ack = 1'b1;
        end
        m_err = 1'b0;
      end else if (entry_matches()) begin
        m_state = 1; m_fail = 0; m_err = 1'b0;
      end else begin
        m_err = 1'b1;
        if (m_fail < MF) m_fail++;
        if (m_fail == MF) begin
          m_state = 2; m_lock_seen = 0;
        end
      end
      m_entry.delete();
    end else if (ev[2]) begin
      if (dig <= 9) begin
        m_err = 1'b0;
        if (m_entry.size() < CL) m_entry.push_back(dig);
      end
    end else if (ev[3] && m_state == 1) begin
      m_state = 0; m_entry.delete(); m_err = 1'b0;
    end
    for (int b = 0; b < 4; b++) begin
      for (int a = 3; a > 0; a--) hist[b][a] = hist[b][a-1];
      hist[b][0] = cur[b];
    end
    for (int a = 3; a > 0; a--) dhist[a] = dhist[a-1];
    dhist[0] = int'(key_digit);
  endtask

  int lock_run = 0, last_run = 0, ack_pulses = 0;

  // Advance the model on every edge and compare all outputs just after it.
  always begin
    @(posedge clk);
    model_step();
    #1;
    check("unlocked",  unlocked,  32'(m_state == 1));
    check("lockout",   lockout,   32'(m_state == 2));
    check("err",       err,       32'(m_err));
    check("prog_ack",  prog_ack,  32'(m_ack));
    check("digit_cnt", digit_cnt, 32'(m_entry.size()));
    check("fail_cnt",  fail_cnt,  32'(m_fail));
    if (lockout === 1'b1) lock_run++;
    else if (lock_run > 0) begin last_run = lock_run; lock_run = 0; end
    if (prog_ack === 1'b1) ack_pulses++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_pin(input int b, input logic v);
    case (b)
      0: clear   = v;
      1: enter   = v;
      2: key_stb = v;
      default: relock = v;
    endcase
  endtask

  task automatic press(input int b, input int d);
    @(negedge clk);
    if (b == 2) key_digit = 4'(d);
    set_pin(b, 1'b1);
    @(negedge clk);
    set_pin(b, 1'b0);
    @(negedge clk);
  endtask

  task automatic type4(input int a, input int b, input int c, input int d);
    press(2, a); press(2, b); press(2, c); press(2, d);
  endtask

  task automatic settle();
    tick(5);
  endtask

  task automatic wait_lock_end();
    for (int i = 0; i < LC + 100; i++) begin
      if (lockout !== 1'b1) break;
      @(negedge clk);
    end
    check("lock_ends", lockout, 0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  int acks0;
  int r;

  initial begin
    rst_n = 1'b0;
    tick(3);
    check("rst_unlocked", unlocked, 0);
    check("rst_lockout",  lockout,  0);
    check("rst_err",      err,      0);
    check("rst_ack",      prog_ack, 0);
    check("rst_dcnt",     digit_cnt, 0);
    check("rst_fcnt",     fail_cnt, 0);
    rst_n = 1'b1;
    tick(2);

    // Correct code opens exactly three edges after the enter pin rises.
    type4(1, 2, 3, 4);
    settle();
    check("dcnt_full", digit_cnt, 4);
    @(negedge clk); enter = 1'b1;
    @(negedge clk); enter = 1'b0;
    @(negedge clk);
    @(negedge clk); check("open_edge2", unlocked, 0);
    @(negedge clk); check("open_edge3", unlocked, 1);
    check("open_fcnt", fail_cnt, 0);
    check("open_dcnt", digit_cnt, 0);
    press(3, 0); settle();
    check("relocked", unlocked, 0);

    // Wrong code sets err; the next key clears it.
    type4(1, 2, 3, 5); press(1, 0); settle();
    check("wrong_err",  err, 1);
    check("wrong_fcnt", fail_cnt, 1);
    check("wrong_unl",  unlocked, 0);
    press(2, 7); settle();
    check("key_clr_err", err, 0);
    press(0, 0); settle();

    // Two more failures lock out; the correct code is ignored meanwhile.
    type4(9, 9, 9, 9); press(1, 0);
    type4(9, 9, 9, 9); press(1, 0); settle();
    check("lock_on",   lockout, 1);
    check("lock_fcnt", fail_cnt, 3);
    type4(1, 2, 3, 4); press(1, 0); settle();
    check("lock_ign_unl", unlocked, 0);
    wait_lock_end();
    tick(2);
    check("lock_len",  last_run, LC);
    check("post_fcnt", fail_cnt, 0);
    type4(1, 2, 3, 4); press(1, 0); settle();
    check("post_open", unlocked, 1);

    // Reprogram while open, relock, then only the new code opens.
    acks0 = ack_pulses;
    type4(9, 8, 7, 6); press(1, 0); settle();
    check("prog_pulses", ack_pulses - acks0, 1);
    check("prog_still_open", unlocked, 1);
    press(3, 0);
    type4(1, 2, 3, 4); press(1, 0); settle();
    check("old_code_err", err, 1);
    check("old_code_unl", unlocked, 0);
    type4(9, 8, 7, 6); press(1, 0); settle();
    check("new_code_open", unlocked, 1);
    type4(1, 2, 3, 4); press(1, 0); press(3, 0); settle();

    // Extra digits and invalid digits are ignored; short entry fails.
    type4(1, 2, 3, 4); press(2, 5); press(2, 12); settle();
    check("extras_dcnt", digit_cnt, 4);
    press(1, 0); settle();
    check("extras_open", unlocked, 1);
    press(3, 0);
    press(2, 1); press(2, 2); press(0, 0); press(1, 0); settle();
    check("short_err",  err, 1);
    check("short_fcnt", fail_cnt, 1);

    // clear beats enter in the same cycle.
    type4(1, 2, 3, 4);
    @(negedge clk); clear = 1'b1; enter = 1'b1;
    @(negedge clk); clear = 1'b0; enter = 1'b0;
    settle();
    check("clr_pri_fcnt", fail_cnt, 1);
    check("clr_pri_unl",  unlocked, 0);
    check("clr_pri_dcnt", digit_cnt, 0);

    // Reset in the middle of lockout aborts it and restores the default code.
    press(1, 0); press(1, 0); settle();
    check("lock2_on", lockout, 1);
    tick(50);
    rst_n = 1'b0; tick(1); rst_n = 1'b1; tick(1);
    check("rst_lock_off", lockout, 0);
    check("rst_lock_fcnt", fail_cnt, 0);
    type4(1, 2, 3, 4); press(1, 0); settle();
    check("rst_code_open", unlocked, 1);
    press(3, 0); settle();

    // Randomized phase; the per-cycle model compare does the checking.
    for (int it = 0; it < 300; it++) begin
      if (m_state == 2 && $urandom_range(0, 1) == 0) wait_lock_end();
      r = $urandom_range(0, 99);
      if (r < 40) begin
        press(2, ($urandom_range(0, 5) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9));
      end else if (r < 52) begin
        press(1, 0);
      end else if (r < 60) begin
        press(0, 0);
      end else if (r < 68) begin
        press(3, 0);
      end else if (r < 84) begin
        int q[$];
        q = m_code;
        foreach (q[i]) press(2, q[i]);
        press(1, 0);
      end else if (r < 88) begin
        @(negedge clk); clear = 1'b1; enter = 1'b1;
        @(negedge clk); clear = 1'b0; enter = 1'b0;
      end else if (r < 97) begin
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          {clear, enter, key_stb, relock} = 4'($urandom_range(0, 15));
          key_digit = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        {clear, enter, key_stb, relock} = '0;
      end else begin
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
      end
      tick($urandom_range(0, 2));
    end
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
